fir_mac_engine: RTL and testbench

Time-multiplexed 64-tap FIR core on the read side of the async sample FIFO. It pops one signed 16-bit sample whenever the FIFO is non-empty and stores it in a circular history buffer. It then runs TAPS multiply-accumulate cycles through a single multiplier and presents one filtered sample on a valid/ready output port. It runs entirely in the FIFO read clock domain and drives the FIFO's `rinc` directly.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_mac_engine_if.sv | 23 ++
 rtl/fir_sample_ring.sv | 41 ++++
 rtl/fir_mac_engine.sv | 168 ++++++++++++++++
 tb/tb_fir_mac_engine.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR MAC engine.
// Holds the FSM state enum, accumulator width and saturation limits.
package fir_pkg;

  localparam int FIR_DSIZE = 16;
  localparam int FIR_TSIZE = 6;
  localparam int FIR_TAPS  = 1 << FIR_TSIZE;
  localparam int ACC_W     = 2 * FIR_DSIZE + FIR_TSIZE;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } state_t;

  // Signed DSIZE-bit range limits, used when clamping the result.
  function automatic longint sat_hi(input int d);
    return (longint'(1) << (d - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int d);
    return -(longint'(1) << (d - 1));
  endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// fir_mac_engine_if: filtered-sample valid/ready output stream.
// Ports: dout, out_valid (master->slave), out_ready (slave->master).
interface fir_mac_engine_if #(
  parameter int DSIZE = 16
);

  logic [DSIZE-1:0] dout;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output dout,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  dout,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fir_sample_ring.sv
// fir_sample_ring: TAPS x DSIZE circular sample history with head pointer.
// Ports: clk, rst_n, we/wdata (write at head), adv (head+1), k -> rd_q.
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int DSIZE = FIR_DSIZE,
  parameter int TAPS  = FIR_TAPS,
  parameter int TSIZE = FIR_TSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [DSIZE-1:0] wdata,
  input  logic             adv,
  input  logic [TSIZE-1:0] k,
  output logic [DSIZE-1:0] rd_q
);

  logic [DSIZE-1:0] hist [TAPS];
  logic [TSIZE-1:0] head;

  // head - k wraps naturally in TSIZE bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      rd_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
      end
    end else begin
      if (we) begin
        hist[head] <= wdata;
      end
      if (adv) begin
        head <= head + TSIZE'(1);
      end
      rd_q <= hist[head - k];
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed TAPS-tap FIR on a FIFO read side.
// Ports: rclk, rrst_n, rdata/rempty/rinc, coef_*, busy, out (if master).
// Build option FIR_SATURATE_EN clamps dout instead of wrapping.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DSIZE = FIR_DSIZE,
  parameter int TAPS  = FIR_TAPS,
  parameter int TSIZE = FIR_TSIZE
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             coef_we,
  input  logic [TSIZE-1:0] coef_addr,
  input  logic [DSIZE-1:0] coef_wdata,
  output logic             busy,
  fir_mac_engine_if.master out
);

  localparam int AW = 2 * DSIZE + TSIZE;

  state_t state;
  state_t state_nxt;

  logic [TSIZE-1:0] k;
  logic             dcnt;
  logic             issue;
  logic             pop;
  logic             last_tap;
  logic             xfer;

  logic        [DSIZE-1:0]   h [TAPS];
  logic signed [DSIZE-1:0]   coef_q;
  logic signed [DSIZE-1:0]   samp_q;
  logic                      rd_v;
  logic signed [2*DSIZE-1:0] prod;
  logic                      prod_v;
  logic signed [AW-1:0]      acc;
  logic        [DSIZE-1:0]   res;

  assign pop      = (state == IDLE) && !rempty;
  assign last_tap = (k == TSIZE'(TAPS - 1));
  assign xfer     = out.out_valid && out.out_ready;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rempty)  state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = DRAIN;
      DRAIN:   if (dcnt)     state_nxt = OUT;
      OUT:     if (xfer)     state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rinc  = 1'b0;
    busy  = 1'b1;
    issue = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        rinc = !rempty;
      end
      MAC:     issue = 1'b1;
      default: ;
    endcase
  end

  fir_sample_ring #(
    .DSIZE (DSIZE),
    .TAPS  (TAPS),
    .TSIZE (TSIZE)
  ) u_ring (
    .clk   (rclk),
    .rst_n (rrst_n),
    .we    (pop),
    .wdata (rdata),
    .adv   (xfer),
    .k     (k),
    .rd_q  (samp_q)
  );

  // Writes only land when idle and not popping.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        h[i] <= '0;
      end
    end else if (coef_we && state == IDLE && rempty) begin
      h[coef_addr] <= coef_wdata;
    end
  end

  // Pipeline: read regs -> product reg -> accumulate.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      k      <= '0;
      dcnt   <= 1'b0;
      coef_q <= '0;
      rd_v   <= 1'b0;
      prod   <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      if (issue) begin
        k <= k + TSIZE'(1);
      end
      if (state == DRAIN) begin
        dcnt <= ~dcnt;
      end
      coef_q <= h[k];
      rd_v   <= issue;
      prod   <= coef_q * samp_q;
      prod_v <= rd_v;
      if (pop) begin
        acc <= '0;
      end else if (prod_v) begin
        acc <= acc + AW'(prod);
      end
    end
  end

`ifdef FIR_SATURATE_EN
  localparam int SW = AW - (DSIZE - 1);
  localparam logic signed [SW-1:0] HI = SW'(sat_hi(DSIZE));
  localparam logic signed [SW-1:0] LO = SW'(sat_lo(DSIZE));

  logic signed [SW-1:0] shifted;
  assign shifted = acc[AW-1:DSIZE-1];

  always_comb begin
    res = shifted[DSIZE-1:0];
    if (shifted > HI) begin
      res = HI[DSIZE-1:0];
    end else if (shifted < LO) begin
      res = LO[DSIZE-1:0];
    end
  end
`else
  assign res = acc[2*DSIZE-2:DSIZE-1];
`endif

  // Result is latched on the first OUT cycle, after the last add.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      out.out_valid <= 1'b0;
      out.dout      <= '0;
    end else if (state == OUT && !out.out_valid) begin
      out.out_valid <= 1'b1;
      out.dout      <= res;
    end else if (xfer) begin
      out.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: scoreboard bench for fir_mac_engine.
// Drives a FIFO model, queues expected outputs, monitor compares.
module tb_fir_mac_engine;

  logic        rclk;
  logic        rrst_n;
  logic [15:0] rdata;
  logic        rempty;
  logic        rinc;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        busy;

  fir_mac_engine_if bif ();

  fir_mac_engine dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rdata      (rdata),
    .rempty     (rempty),
    .rinc       (rinc),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy),
    .out        (bif)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int npop = 0;
  bit pend = 0;
  bit ov_d = 0;

  logic [15:0] fifo [$];
  logic [15:0] exp_q [$];
  int          pop_t [$];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  always @(posedge rclk) cyc++;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endfunction

  // FIFO model: rinc seen mid-cycle pops at the next edge.
  always @(negedge rclk) pend = rinc && rrst_n;

  always @(posedge rclk) begin
    #1;
    if (pend && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pop_t.push_back(cyc);
      npop++;
    end
    pend = 0;
    rempty = (fifo.size() == 0);
    rdata = rempty ? 16'h0000 : fifo[0];
  end

  // Monitor: latency on out_valid rise, data on each transfer.
  always @(negedge rclk) begin
    if (rrst_n) begin
      if (bif.out_valid && !ov_d) begin
        if (pop_t.size() == 0) begin
          fail_now("latency_nopop");
        end else begin
          chk("latency", cyc - pop_t.pop_front(), 67);
        end
      end
      if (bif.out_valid && bif.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected dout 0x%0h", bif.dout));
        end else begin
          chk("dout", int'(bif.dout), int'(exp_q.pop_front()));
        end
      end
    end
    ov_d = bif.out_valid;
  end

  task automatic wr_coef(input int a, input logic [15:0] v);
    coef_we = 1'b1;
    coef_addr = 6'(a);
    coef_wdata = v;
    @(posedge rclk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || busy
            || bif.out_valid) && n < budget) begin
      @(negedge rclk);
      n++;
    end
    if (n >= budget) fail_now("timeout wait_idle");
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      @(posedge rclk);
      #1;
      n++;
    end
    if (!busy) fail_now("timeout wait_busy");
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    pop_t.delete();
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int d0;
    int p0;
    logic [15:0] e;

    rrst_n = 1'b1;
    rempty = 1'b1;
    rdata = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    bif.out_ready = 1'b1;
    #3 rrst_n = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", bif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", bif.dout, 0);
    @(negedge rclk);
    rrst_n = 1'b1;

    bad = 0;
    repeat (200) begin
      @(negedge rclk);
      if (rinc || busy || bif.out_valid) bad++;
    end
    chk("empty_hold", bad, 0);

    // Impulse: h[k]=k+1, 0x7FFF*(k+1)>>>15 = k.
    @(posedge rclk);
    #1;
    for (int i = 0; i < 64; i++) wr_coef(i, 16'(i + 1));
    for (int i = 0; i < 64; i++) begin
      fifo.push_back(i == 0 ? 16'h7FFF : 16'h0000);
      exp_q.push_back(16'(i));
    end
    wait_idle(64 * 80);

    // Saturation: j full-scale samples -> 32766*j before narrowing.
    @(posedge rclk);
    #1;
    for (int i = 0; i < 64; i++) wr_coef(i, 16'h7FFF);
    for (int j = 1; j <= 64; j++) begin
      fifo.push_back(16'h7FFF);
`ifdef FIR_SATURATE_EN
      e = (j == 1) ? 16'h7FFE : 16'h7FFF;
`else
      e = 16'(32766 * j);
`endif
      exp_q.push_back(e);
    end
    wait_idle(64 * 80);

    // Coefficient guard.
    do_reset();
    fifo.push_back(16'h2000);
    exp_q.push_back(16'h0000);
    wait_busy(20);
    repeat (5) @(posedge rclk);
    #1;
    wr_coef(0, 16'h4000);
    wait_idle(200);
    fifo.push_back(16'h2000);
    exp_q.push_back(16'h0000);
    wait_idle(200);
    @(posedge rclk);
    #1;
    wr_coef(0, 16'h4000);
    fifo.push_back(16'h2000);
    exp_q.push_back(16'h1000);
    wait_idle(200);

    // Backpressure with a second sample waiting.
    @(posedge rclk);
    #1;
    bif.out_ready = 1'b0;
    fifo.push_back(16'h7FFF);
    fifo.push_back(16'h2000);
    exp_q.push_back(16'h3FFF);
    exp_q.push_back(16'h1000);
    bad = 0;
    while (!bif.out_valid && bad < 100) begin
      @(negedge rclk);
      bad++;
    end
    if (!bif.out_valid) fail_now("timeout out_valid");
    d0 = bif.dout;
    repeat (10) begin
      @(negedge rclk);
      chk("bp_rempty", rempty, 0);
      chk("bp_dout", bif.dout, d0);
      chk("bp_rinc", rinc, 0);
    end
    @(posedge rclk);
    #1;
    p0 = npop;
    bif.out_ready = 1'b1;
    repeat (10) @(posedge rclk);
    #1;
    chk("bp_one_pop", npop - p0, 1);
    wait_idle(200);

    // Reset at MAC cycle 20.
    fifo.push_back(16'h7FFF);
    wait_busy(20);
    repeat (20) @(posedge rclk);
    #2;
    rrst_n = 1'b0;
    pop_t.delete();
    #1;
    chk("mid_rinc", rinc, 0);
    chk("mid_valid", bif.out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_dout", bif.dout, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (5) @(negedge rclk);
    fifo.push_back(16'h7FFF);
    exp_q.push_back(16'h0000);
    wait_idle(200);
    repeat (100) @(negedge rclk);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
